// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fq_entry_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

   // Instructions are word aligned; low address bits of a target are dropped.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small FIFO of fetched {pc, inst} pairs feeding decode
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  fq_entry_t   push_data,
   input  logic        pop,
   input  logic        flush,
   output fq_entry_t   head,
   output logic [AW:0] count,
   output logic        empty
);

   fq_entry_t      mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic           full;

   // Storage is not reset: count alone decides which slots are meaningful.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; a flush wins over a same-cycle push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            count <= count + (AW+1)'(1);
         end else if (pop && !push) begin
            count <= count - (AW+1)'(1);
         end
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));

   // The issue logic reserves a slot for every lookup in flight, so a push
   // into a full queue without a matching pop means that reservation broke.
   assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && !flush && full));

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - fetch PC owner, icache request driver and decode-side queue
module ifu_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          FQ_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] ic_pc,
   output logic        ic_en,
   input  logic [31:0] ic_inst,
   input  logic        ic_valid,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst
);

   localparam int              AW      = $clog2(FQ_DEPTH);
   localparam logic [AW+1:0]   DEPTH_V = (AW+2)'(FQ_DEPTH);

   fetch_state_e  state_q;
   fetch_state_e  state_d;
   logic [31:0]   fetch_pc_q;
   logic [31:0]   req_pc_q;
   logic          missing;
   logic          push;
   logic          pop;
   logic          can_issue;
   logic          q_empty;
   logic [AW:0]   count;
   logic [AW+1:0] occ_next;
   fq_entry_t     push_data;
   fq_entry_t     head;

   // Issue decision, icache request and next state; a lookup is only issued
   // when the queue will still have room for its response.
   always_comb begin
      missing   = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      id_valid  = 1'b0;
      occ_next  = '0;
      can_issue = 1'b0;
      ic_en     = 1'b0;
      ic_pc     = fetch_pc_q;
      state_d   = state_q;

      missing   = (state_q == BUSY) && !ic_valid;
      push      = (state_q == BUSY) && ic_valid && !redirect_valid;
      id_valid  = !q_empty && !redirect_valid;
      pop       = id_valid && id_ready;
      occ_next  = {1'b0, count} + (AW+2)'(push) - (AW+2)'(pop);
      can_issue = (occ_next < DEPTH_V) && !missing;
      ic_en     = rst_n && (redirect_valid || can_issue);

      if (!rst_n) begin
         ic_pc = RESET_PC;
      end else if (redirect_valid) begin
         ic_pc = align_pc(redirect_pc);
      end else if (missing) begin
         ic_pc = req_pc_q;
      end

      if (ic_en) begin
         state_d = BUSY;
      end else if ((state_q == BUSY) && ic_valid) begin
         state_d = IDLE;
      end
   end

   // Fetch state and PCs; req_pc_q names the lookup whose response is due.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
      end else begin
         state_q <= state_d;
         if (ic_en) begin
            req_pc_q   <= ic_pc;
            fetch_pc_q <= ic_pc + 32'd4;
         end
      end
   end

   assign push_data.pc   = req_pc_q;
   assign push_data.inst = ic_inst;

   fetch_queue #(
      .DEPTH(FQ_DEPTH)
   ) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (head),
      .count     (count),
      .empty     (q_empty)
   );

   assign id_pc   = head.pc;
   assign id_inst = head.inst;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch
module tb_ifu_fetch;

   localparam logic [31:0] B = 32'h8000_0000;
   localparam logic [31:0] K = 32'hA5A5_A5A5;

   typedef struct packed {
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic        miss;
      logic        en;
      logic [31:0] pc;
      logic        idv;
      logic [31:0] idpc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] ic_pc;
   logic        ic_en;
   logic [31:0] ic_inst;
   logic        ic_valid;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_inst;

   int          total = 0;
   int          bad = 0;
   logic        ic_act;
   logic [31:0] ic_lpc;
   logic [31:0] exp_pc;
   int          acc;
   logic        got;
   vec_t        tbl [$];

   always #5 clk = ~clk;

   ifu_fetch #(
      .RESET_PC (B),
      .FQ_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ic_pc          (ic_pc),
      .ic_en          (ic_en),
      .ic_inst        (ic_inst),
      .ic_valid       (ic_valid),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_inst        (id_inst)
   );

   function automatic logic [31:0] f_inst(input logic [31:0] pc);
      return pc ^ K;
   endfunction

   function automatic vec_t v(input logic r, input logic d, input logic [31:0] rp, input logic m,
                              input logic e, input logic [31:0] p, input logic iv, input logic [31:0] ip);
      vec_t t;
      t.ready = r; t.redir = d; t.rpc = rp; t.miss = m;
      t.en = e; t.pc = p; t.idv = iv; t.idpc = ip;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // icache response for the cycle just started: hit/miss for an outstanding
   // lookup, stale garbage when nothing is outstanding
   task automatic apply(input logic rdy, input logic rv, input logic [31:0] rp, input logic miss);
      id_ready       = rdy;
      redirect_valid = rv;
      redirect_pc    = rp;
      if (ic_act) begin
         ic_valid = !miss;
         ic_inst  = miss ? $urandom : f_inst(ic_lpc);
      end else begin
         ic_valid = 1'($urandom);
         ic_inst  = $urandom;
      end
   endtask

   // icache view of lookups: a new one at each enabled edge, a miss repeats
   task automatic track_ic();
      if (ic_en) begin
         ic_act = 1'b1;
         ic_lpc = ic_pc;
      end else if (ic_act && ic_valid) begin
         ic_act = 1'b0;
      end
   endtask

   task automatic run_vec(input vec_t t, input int idx);
      apply(t.ready, t.redir, t.rpc, t.miss);
      @(negedge clk);
      chk($sformatf("row%0d ic_en", idx), 32'(ic_en), 32'(t.en));
      chk($sformatf("row%0d ic_pc", idx), ic_pc, t.pc);
      chk($sformatf("row%0d id_valid", idx), 32'(id_valid), 32'(t.idv));
      if (t.idv) begin
         chk($sformatf("row%0d id_pc", idx), id_pc, t.idpc);
         chk($sformatf("row%0d id_inst", idx), id_inst, f_inst(t.idpc));
      end
      track_ic();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      ic_act         = 1'b0;
      id_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      ic_valid       = 1'b0;
      ic_inst        = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic async_reset_check(input string tag);
      #2;
      rst_n  = 1'b0;
      ic_act = 1'b0;
      #1;
      chk({tag, " id_valid"}, 32'(id_valid), 32'd0);
      chk({tag, " ic_en"}, 32'(ic_en), 32'd0);
      chk({tag, " ic_pc"}, ic_pc, B);
   endtask

   initial begin
      // streaming, 3-cycle miss, backpressure, redirects incl. wrap and back-to-back
      tbl.push_back(v(1, 0, 0,            0, 1, B,            0, 0));
      tbl.push_back(v(1, 0, 0,            0, 1, B + 32'h4,    0, 0));
      tbl.push_back(v(1, 0, 0,            0, 1, B + 32'h8,    1, B));
      tbl.push_back(v(1, 0, 0,            1, 0, B + 32'h8,    1, B + 32'h4));
      tbl.push_back(v(1, 0, 0,            1, 0, B + 32'h8,    0, 0));
      tbl.push_back(v(1, 0, 0,            1, 0, B + 32'h8,    0, 0));
      tbl.push_back(v(1, 0, 0,            0, 1, B + 32'hC,    0, 0));
      tbl.push_back(v(1, 0, 0,            0, 1, B + 32'h10,   1, B + 32'h8));
      tbl.push_back(v(0, 0, 0,            0, 0, B + 32'h14,   1, B + 32'hC));
      tbl.push_back(v(0, 0, 0,            0, 0, B + 32'h14,   1, B + 32'hC));
      tbl.push_back(v(1, 0, 0,            0, 1, B + 32'h14,   1, B + 32'hC));
      tbl.push_back(v(1, 0, 0,            0, 1, B + 32'h18,   1, B + 32'h10));
      tbl.push_back(v(1, 0, 0,            0, 1, B + 32'h1C,   1, B + 32'h14));
      tbl.push_back(v(1, 1, B + 32'h102,  0, 1, B + 32'h100,  0, 0));
      tbl.push_back(v(1, 0, 0,            0, 1, B + 32'h104,  0, 0));
      tbl.push_back(v(1, 0, 0,            0, 1, B + 32'h108,  1, B + 32'h100));
      tbl.push_back(v(1, 0, 0,            1, 0, B + 32'h108,  1, B + 32'h104));
      tbl.push_back(v(1, 1, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 0, 0));
      tbl.push_back(v(1, 0, 0,            0, 1, 32'h0,        0, 0));
      tbl.push_back(v(1, 0, 0,            0, 1, 32'h4,        1, 32'hFFFF_FFFC));
      tbl.push_back(v(1, 0, 0,            0, 1, 32'h8,        1, 32'h0));
      tbl.push_back(v(1, 0, 0,            0, 1, 32'hC,        1, 32'h4));
      tbl.push_back(v(1, 1, 32'h1003,     0, 1, 32'h1000,     0, 0));
      tbl.push_back(v(1, 1, 32'h2001,     0, 1, 32'h2000,     0, 0));
      tbl.push_back(v(1, 0, 0,            0, 1, 32'h2004,     0, 0));
      tbl.push_back(v(1, 0, 0,            0, 1, 32'h2008,     1, 32'h2000));

      rst_n          = 1'b0;
      id_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      ic_valid       = 1'b0;
      ic_inst        = '0;
      ic_act         = 1'b0;
      #1;
      chk("reset ic_en", 32'(ic_en), 32'd0);
      chk("reset ic_pc", ic_pc, B);
      chk("reset id_valid", 32'(id_valid), 32'd0);

      do_reset();
      foreach (tbl[i]) run_vec(tbl[i], i);

      // reset with a full queue
      do_reset();
      run_vec(v(0, 0, 0, 0, 1, B,         0, 0), 100);
      run_vec(v(0, 0, 0, 0, 1, B + 32'h4, 0, 0), 101);
      run_vec(v(0, 0, 0, 0, 0, B + 32'h8, 1, B), 102);
      run_vec(v(0, 0, 0, 0, 0, B + 32'h8, 1, B), 103);
      async_reset_check("rst_full");

      // reset in the middle of a miss with an entry queued
      do_reset();
      run_vec(v(0, 0, 0, 0, 1, B,         0, 0), 110);
      run_vec(v(0, 0, 0, 0, 1, B + 32'h4, 0, 0), 111);
      run_vec(v(0, 0, 0, 1, 0, B + 32'h4, 1, B), 112);
      async_reset_check("rst_miss");
      do_reset();
      run_vec(v(1, 0, 0, 0, 1, B,         0, 0), 120);
      run_vec(v(1, 0, 0, 0, 1, B + 32'h4, 0, 0), 121);
      run_vec(v(1, 0, 0, 0, 1, B + 32'h8, 1, B), 122);

      // random traffic against an in-order program-stream model
      do_reset();
      exp_pc = B;
      acc    = 0;
      for (int n = 0; n < 4000; n++) begin
         logic        rdy;
         logic        rv;
         logic        ms;
         logic [31:0] rp;
         rdy = ($urandom % 4) != 0;
         rv  = ($urandom % 32) == 0;
         ms  = ($urandom % 4) == 0;
         rp  = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
         apply(rdy, rv, rp, ms);
         @(negedge clk);
         if (rv) begin
            chk("rnd redir ic_en", 32'(ic_en), 32'd1);
            chk("rnd redir ic_pc", ic_pc, {rp[31:2], 2'b00});
            chk("rnd redir id_valid", 32'(id_valid), 32'd0);
         end
         if (id_valid && id_ready) begin
            chk("rnd id_pc", id_pc, exp_pc);
            chk("rnd id_inst", id_inst, f_inst(exp_pc));
            exp_pc = exp_pc + 32'd4;
            acc++;
         end
         if (rv) exp_pc = {rp[31:2], 2'b00};
         track_ic();
         @(posedge clk);
         #1;
      end

      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         apply(1'b1, 1'b0, '0, 1'b0);
         @(negedge clk);
         if (id_valid) begin
            chk("drain id_pc", id_pc, exp_pc);
            got = 1'b1;
         end
         track_ic();
         @(posedge clk);
         #1;
      end
      chk("drain progress", 32'(got), 32'd1);
      chk("rnd throughput", 32'(acc > 500), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
